// File: rtl/phase_scheduler.sv
// Intersection phase sequencer: walks GREEN/LEFT/YELLOW/ALLRED per approach, interleaves
// round-robin pedestrian WALK phases and honours emergency preempt toward one approach.
//
// state  | meaning
// ALLRED | every approach red; exits to WALK (after YELLOW, requests pending) or GREEN
// GREEN  | phase_dir approach has through green
// LEFT   | protected left turn for phase_dir (day only)
// YELLOW | clearance for phase_dir
// WALK   | pedestrian crossing phase_dir is served
module phase_scheduler #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int GREEN_DAY   = 20,
  parameter int GREEN_NIGHT = 10,
  parameter int LEFT_T      = 5,
  parameter int YELLOW_T    = 3,
  parameter int ALLRED_T    = 1,
  parameter int WALK_T      = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       daynight,
  input  logic [3:0] walk_req,
  input  logic       preempt,
  input  logic [1:0] preempt_dir,
  output logic [2:0] phase_st,
  output logic [1:0] phase_dir,
  output logic [7:0] remaining,
  output logic [3:0] walk_pending,
  output logic       phase_start
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    ST_ALLRED = 3'd0,
    ST_GREEN  = 3'd1,
    ST_LEFT   = 3'd2,
    ST_YELLOW = 3'd3,
    ST_WALK   = 3'd4
  } phase_e;

  phase_e          phase_st_q, phase_st_d;
  logic [1:0]      phase_dir_q, phase_dir_d;
  logic [7:0]      remaining_q, remaining_d;
  logic [3:0]      walk_pending_q, walk_pending_d;
  logic            phase_start_q, phase_start_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      last_served_q, last_served_d;
  logic            prev_yellow_q, prev_yellow_d;
  logic [1:0]      saved_dir_q, saved_dir_d;
  logic            green_day_q, green_day_d;

  logic            tick, expire, on_target, hold_green;
  logic            enter, enter_walk, walk_abort;
  logic [1:0]      walk_sel;

  assign tick       = (presc_q == PW'(TICK_DIV - 1));
  assign expire     = tick && (remaining_q == 8'd1);
  assign on_target  = (phase_dir_q == preempt_dir);
  assign hold_green = preempt && (phase_st_q == ST_GREEN) && on_target;

  // First pending crossing searching upward from the one after last_served.
  always_comb begin
    logic [1:0] cand;
    cand     = '0;
    walk_sel = last_served_q;
    for (int k = 3; k >= 0; k--) begin
      cand = last_served_q + 2'd1 + 2'(k);
      if (walk_pending_q[cand]) walk_sel = cand;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_st_q     <= ST_ALLRED;
      phase_dir_q    <= 2'd0;
      remaining_q    <= 8'(ALLRED_T);
      walk_pending_q <= 4'd0;
      phase_start_q  <= 1'b0;
      presc_q        <= '0;
      last_served_q  <= 2'd3;
      prev_yellow_q  <= 1'b0;
      saved_dir_q    <= 2'd0;
      green_day_q    <= 1'b0;
    end else begin
      phase_st_q     <= phase_st_d;
      phase_dir_q    <= phase_dir_d;
      remaining_q    <= remaining_d;
      walk_pending_q <= walk_pending_d;
      phase_start_q  <= phase_start_d;
      presc_q        <= presc_d;
      last_served_q  <= last_served_d;
      prev_yellow_q  <= prev_yellow_d;
      saved_dir_q    <= saved_dir_d;
      green_day_q    <= green_day_d;
    end
  end

  always_comb begin
    phase_st_d = phase_st_q;
    case (phase_st_q)
      ST_ALLRED: if (expire)
        phase_st_d = (prev_yellow_q && (|walk_pending_q) && !preempt) ? ST_WALK : ST_GREEN;
      ST_GREEN: begin
        if (preempt && !on_target)  phase_st_d = ST_YELLOW;
        else if (expire && !preempt) phase_st_d = green_day_q ? ST_LEFT : ST_YELLOW;
      end
      ST_LEFT:   if (preempt || expire) phase_st_d = ST_YELLOW;
      ST_YELLOW: if (expire) phase_st_d = ST_ALLRED;
      ST_WALK:   if (preempt || expire) phase_st_d = ST_ALLRED;
      default:   phase_st_d = ST_ALLRED;
    endcase
  end

  always_comb begin
    enter         = (phase_st_d != phase_st_q);
    enter_walk    = enter && (phase_st_d == ST_WALK);
    walk_abort    = (phase_st_q == ST_WALK) && preempt;
    phase_start_d = enter;
    presc_d       = (enter || tick) ? '0 : presc_q + PW'(1);
    phase_dir_d   = phase_dir_q;
    remaining_d   = remaining_q;
    last_served_d = last_served_q;
    prev_yellow_d = prev_yellow_q;
    saved_dir_d   = saved_dir_q;
    green_day_d   = green_day_q;

    if (enter) begin
      prev_yellow_d = (phase_st_q == ST_YELLOW);
      case (phase_st_d)
        ST_ALLRED: begin
          remaining_d = 8'(ALLRED_T);
          if (preempt)                     phase_dir_d = preempt_dir;
          else if (phase_st_q == ST_WALK)  phase_dir_d = saved_dir_q;
          else                             phase_dir_d = phase_dir_q + 2'd1;
        end
        ST_GREEN: begin
          remaining_d = daynight ? 8'(GREEN_DAY) : 8'(GREEN_NIGHT);
          green_day_d = daynight;
        end
        ST_LEFT:   remaining_d = 8'(LEFT_T);
        ST_YELLOW: remaining_d = 8'(YELLOW_T);
        ST_WALK: begin
          remaining_d   = 8'(WALK_T);
          saved_dir_d   = phase_dir_q;
          phase_dir_d   = walk_sel;
          last_served_d = walk_sel;
        end
        default: remaining_d = 8'(ALLRED_T);
      endcase
    end else if (tick && !hold_green) begin
      remaining_d = remaining_q - 8'd1;
    end

    // A request arriving on the cycle its WALK starts is absorbed by that WALK.
    walk_pending_d = walk_pending_q | walk_req;
    if (enter_walk) walk_pending_d[walk_sel] = 1'b0;
    if (walk_abort) walk_pending_d[phase_dir_q] = 1'b1;
  end

  assign phase_st     = phase_st_q;
  assign phase_dir    = phase_dir_q;
  assign remaining    = remaining_q;
  assign walk_pending = walk_pending_q;
  assign phase_start  = phase_start_q;

endmodule

// File: doc/phase_scheduler.md
# phase_scheduler

Sequences the four-approach intersection through its signal phases and decides which approach or pedestrian crossing holds the right-of-way at any moment. It sits between the clock block, whose `daynight` output it consumes, and the lamp-driver/state-decoder logic, which consumes `phase_st`, `phase_dir` and `remaining`. It latches pedestrian requests and serves them round-robin between vehicle phases. An emergency preempt input forces a chosen approach to green.

## Interface
- `TICK_DIV`, 50_000_000: clk cycles per one-second tick; minimum 2.
- `GREEN_DAY`, 20: GREEN duration in seconds when `daynight`=1.
- `GREEN_NIGHT`, 10: GREEN duration in seconds when `daynight`=0.
- `LEFT_T`, 5: LEFT (protected turn) duration in seconds.
- `YELLOW_T`, 3: YELLOW duration in seconds.
- `ALLRED_T`, 1: ALLRED duration in seconds.
- `WALK_T`, 10: WALK duration in seconds.
- All durations are 1..255.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: asynchronous, active-low reset.
- `daynight` in 1: 1 = day, 0 = night.
- `walk_req` in 4: per-crossing request; level-sampled every cycle and already debounced.
- `preempt` in 1: emergency preempt request, level.
- `preempt_dir` in 2: approach that must receive green during preempt.
- `phase_st` out 3: current phase. 0 = ALLRED, 1 = GREEN, 2 = LEFT, 3 = YELLOW, 4 = WALK.
- `phase_dir` out 2: approach (GREEN/LEFT/YELLOW/ALLRED) or crossing (WALK) that owns the phase.
- `remaining` out 8: whole seconds left in the current phase.
- `walk_pending` out 4: latched, not-yet-served pedestrian requests.
- `phase_start` out 1: one-cycle pulse on the first cycle of every new phase.

## Operation
- **Prescaler.** Counts 0..TICK_DIV-1 and asserts `tick` at TICK_DIV-1. It clears on every phase entry, so a phase of D seconds lasts exactly D×TICK_DIV cycles.
- **Countdown.** Phase entry loads `remaining` = D. On each tick, `remaining`=1 exits the phase; otherwise `remaining` decrements.
- **Green length.** GREEN loads GREEN_DAY or GREEN_NIGHT according to `daynight` sampled at GREEN entry. A later change of `daynight` does not alter a running GREEN.
- **Normal transitions:**
  - GREEN → LEFT when day, or GREEN → YELLOW when night.
  - LEFT → YELLOW.
  - YELLOW → ALLRED. `phase_dir` becomes `preempt` ? `preempt_dir` : `phase_dir`+1 (mod 4).
  - ALLRED → WALK if the previous phase was YELLOW, `walk_pending`≠0 and `preempt`=0. Otherwise ALLRED → GREEN on the current `phase_dir`.
  - WALK → ALLRED. `phase_dir` is restored to the vehicle approach saved at WALK entry; that ALLRED exits to GREEN.
- **Walk arbitration.** Serve the first set bit of `walk_pending` searching from (last_served+1) mod 4. last_served resets to 3. During WALK, `phase_dir` = the crossing index.
- **Pending latch.**
  - Set: `walk_pending[i]` sets when `walk_req[i]`=1.
  - Clear: the bit clears on the cycle WALK i starts. If set and clear coincide for the same bit, clear wins.
- **Preempt**, evaluated every cycle:
  - GREEN on `phase_dir`≠`preempt_dir`, or any LEFT: go to YELLOW next cycle with `remaining`=YELLOW_T.
  - GREEN on `phase_dir`=`preempt_dir`: countdown frozen, so `remaining` holds. The countdown resumes on the first tick after `preempt` falls.
  - WALK: abort to ALLRED next cycle. `phase_dir` := `preempt_dir`, and the aborted crossing's `walk_pending` bit is set again.
  - YELLOW and ALLRED run to completion. ALLRED skips WALK while `preempt`=1.
  - A change of `preempt_dir` during preempt is treated as a new target by the same rules.

## Timing
- **Reset values:** `phase_st`=ALLRED, `phase_dir`=0, `remaining`=ALLRED_T, `walk_pending`=0, `phase_start`=0, prescaler=0, last_served=3, previous phase marked non-YELLOW.
- **First phase.** The first GREEN is on approach 0, entered ALLRED_T×TICK_DIV cycles after reset release. `phase_start` pulses that cycle.
- **Phase change latency.** On the cycle after the ending tick, `phase_st`, `phase_dir` and `remaining` take their new values together, and `phase_start`=1 in that same cycle.
- **Preempt reaction.** `phase_st` changes on the first clock edge after `preempt` is sampled high.
- **Registered outputs.** All outputs are registered; there is no combinational path from input to output.
- **Reset mid-phase.** Asynchronous reset forces the reset values immediately. Pending requests and preempt history are discarded.

## Test plan
- **Reset and first phase:**
  - Stimulus: TICK_DIV=4, GREEN_DAY=3, LEFT_T=2, YELLOW_T=1, ALLRED_T=1, `daynight`=1, no requests.
  - Required: `phase_st` sequence 0 → 1 → 2 → 3 → 0 lasting 4/12/8/4 cycles, then GREEN on approach 1.
  - Required: `phase_start` pulses exactly 5 times in that span.
- **Night and day change:**
  - Stimulus: `daynight`=0 at GREEN entry, then toggled to 1 mid-GREEN.
  - Required: GREEN lasts GREEN_NIGHT×TICK_DIV cycles and LEFT is skipped (GREEN → YELLOW).
- **Walk round-robin:**
  - Stimulus: `walk_req`=4'b1010 for 1 cycle during GREEN on approach 0.
  - Required: after that approach's ALLRED, WALK `phase_dir`=1; after the next approach's ALLRED, WALK `phase_dir`=3.
  - Required: `walk_pending` is 4'b1010 → 4'b1000 → 4'b0000.
- **Preempt mid-green:**
  - Stimulus: GREEN on approach 0, then `preempt`=1 with `preempt_dir`=2.
  - Required: YELLOW on approach 0 next cycle, then ALLRED, then GREEN on approach 2, whose `remaining` holds while preempt=1.
  - Required: after release, the countdown continues, followed by YELLOW and next approach 3.
- **Preempt during walk:**
  - Stimulus: WALK on crossing 1, then `preempt`=1 with `preempt_dir`=0.
  - Required: ALLRED next cycle and `walk_pending[1]` re-set to 1, then GREEN on approach 0.
- **Reset mid-operation:**
  - Stimulus: assert `rst`=0 during LEFT with `walk_pending`=4'b0110.
  - Required: all outputs at reset values within the same cycle, and the pending requests cleared.
